skew_a: RTL and testbench

Diagonal skew stage between `buffer_a` and the systolic MMU. It accepts one flattened `MMU_SIZE`-lane column per cycle, as produced by `buffer_a` on `CMD_SEND`. It delays lane k by k cycles, so that element row k enters the array edge in wavefront order. It also masks lanes beyond the active matrix height, supports stall and clear, and reports drain completion to the controller.

---
 rtl/skew_a.sv | 78 +++++++
 tb/tb_skew_a.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/skew_a.sv
// skew_a: diagonal skew stage; lane k of each column is delayed k cycles on its way to the array edge.
module skew_a #(
  parameter int VAR_SIZE = 8,
  parameter int MMU_SIZE = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [VAR_SIZE*MMU_SIZE-1:0] in_data,
  input  logic [4:0]                   dim_y,
  input  logic                         stop,
  input  logic                         clear,
  output logic [VAR_SIZE*MMU_SIZE-1:0] out_data,
  output logic [MMU_SIZE-1:0]          out_valid,
  output logic                         busy,
  output logic                         done,
  output logic [15:0]                  vec_count
);
  logic                accept;
  logic [4:0]          dim_eff;
  logic [MMU_SIZE-1:0] any_v;
  logic [MMU_SIZE-1:0] inner_v;
  logic [15:0]         vec_count_d, vec_count_q;
  logic                done_d, done_q;
  assign accept  = in_valid & ~stop & ~clear;
  assign dim_eff = (dim_y == 5'd0 || dim_y > 5'(MMU_SIZE)) ? 5'(MMU_SIZE) : dim_y;
  for (genvar k = 0; k < MMU_SIZE; k++) begin : g_lane
    logic [VAR_SIZE-1:0] dat_q [k+1];
    logic [VAR_SIZE-1:0] dat_d [k+1];
    logic [k:0]          vld_q, vld_d;
    logic                lane_en;
    assign lane_en = accept && (5'(k) < dim_eff);
    always_comb begin
      dat_d = dat_q;
      vld_d = vld_q;
      if (clear) begin
        for (int j = 0; j <= k; j++) dat_d[j] = '0;
        vld_d = '0;
      end else if (!stop) begin
        dat_d[0] = lane_en ? in_data[k*VAR_SIZE +: VAR_SIZE] : '0;
        vld_d[0] = lane_en;
        for (int j = 1; j <= k; j++) begin
          dat_d[j] = dat_q[j-1];
          vld_d[j] = vld_q[j-1];
        end
      end
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j <= k; j++) dat_q[j] <= '0;
        vld_q <= '0;
      end else begin
        dat_q <= dat_d;
        vld_q <= vld_d;
      end
    end
    assign out_data[k*VAR_SIZE +: VAR_SIZE] = dat_q[k];
    assign out_valid[k] = vld_q[k];
    assign any_v[k]     = |vld_q;
    // every stage but the output register; shifting left drops the top bit
    assign inner_v[k]   = |(vld_q << 1);
  end
  // a column entering this same edge only fills stage 0, so it cannot hold off done
  assign done_d      = clear ? 1'b0 : stop ? done_q : (|out_valid) && !(|inner_v);
  assign vec_count_d = clear ? 16'd0 : accept ? vec_count_q + 16'd1 : vec_count_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q      <= 1'b0;
      vec_count_q <= '0;
    end else begin
      done_q      <= done_d;
      vec_count_q <= vec_count_d;
    end
  end
  assign busy      = |any_v;
  assign done      = done_q;
  assign vec_count = vec_count_q;
endmodule

// File: tb/tb_skew_a.sv
// tb_skew_a: scoreboard bench for skew_a; each accepted lane is queued with the edge count at which it must appear.
module tb_skew_a;
  localparam int VS = 8;
  localparam int MS = 10;
  localparam int W  = VS * MS;
  logic          clk = 0, rst_n = 0, in_valid = 0, stop = 0, clear = 0;
  logic [W-1:0]  in_data = '0;
  logic [4:0]    dim_y = 5'd10;
  logic [W-1:0]  out_data;
  logic [MS-1:0] out_valid;
  logic          busy, done;
  logic [15:0]   vec_count;
  skew_a #(.VAR_SIZE(VS), .MMU_SIZE(MS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .dim_y(dim_y),
    .stop(stop), .clear(clear), .out_data(out_data), .out_valid(out_valid),
    .busy(busy), .done(done), .vec_count(vec_count)
  );
  always #5 clk = ~clk;
  typedef struct {int due; int lane; logic [VS-1:0] v;} item_t;
  item_t sb[$];
  int checks = 0, failures = 0, ecount = 0, cn = 0, done_at = -1, done_cnt = 0;
  logic done_exp = 0, done_next = 0;
  logic [15:0] vec_exp = 0;
  logic [MS-1:0] ov_or = '0;
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  function automatic logic [W-1:0] col(input int base, input int step);
    logic [W-1:0] r;
    for (int k = 0; k < MS; k++) r[k*VS +: VS] = VS'(base + step * k);
    return r;
  endfunction
  task automatic compare();
    logic [W-1:0] ed;
    logic [MS-1:0] ev;
    logic later;
    for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].due < ecount) sb.delete(i);
    ed = '0; ev = '0; later = 0;
    foreach (sb[i]) begin
      if (sb[i].due == ecount) begin
        ed[sb[i].lane*VS +: VS] = sb[i].v;
        ev[sb[i].lane] = 1'b1;
      end else later = 1'b1;
    end
    check("out_data", out_data, ed);
    check("out_valid", W'(out_valid), W'(ev));
    check("busy", W'(busy), W'(ev != 0 || later));
    check("done", W'(done), W'(done_exp));
    check("vec_count", W'(vec_count), W'(vec_exp));
    done_next = (ev != 0) && !later;
    ov_or |= out_valid;
    if (done) begin
      done_cnt++;
      if (done_at < 0) done_at = cn;
    end
  endtask
  task automatic cyc(input logic iv, input logic [W-1:0] d, input logic [4:0] dy, input logic st, input logic cl);
    int de;
    in_valid = iv; in_data = d; dim_y = dy; stop = st; clear = cl;
    @(posedge clk);
    if (cl) begin
      sb.delete(); vec_exp = 0; done_exp = 0;
    end else if (!st) begin
      done_exp = done_next;
      ecount++;
      if (iv) begin
        de = (dy == 0 || dy > MS) ? MS : int'(dy);
        vec_exp++;
        for (int k = 0; k < de; k++) sb.push_back('{ecount + k, k, d[k*VS +: VS]});
      end
    end
    cn++;
    @(negedge clk);
    compare();
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(1'b0, '0, 5'd10, 1'b0, 1'b0);
  endtask
  task automatic start();
    cn = 0; done_at = -1; done_cnt = 0; ov_or = '0;
  endtask
  initial begin
    logic [4:0] dys [3];
    logic [MS-1:0] ovx [3];
    dys = '{5'd1, 5'd0, 5'd15};
    ovx = '{10'h001, 10'h3FF, 10'h3FF};
    #12 rst_n = 1;
    @(negedge clk);
    compare();
    start();
    cyc(1, col(1, 1), 10, 0, 0);
    idle(14);
    check("s1_done_cycle", W'(done_at), W'(11));
    check("s1_done_pulses", W'(done_cnt), W'(1));
    start();
    for (int c = 0; c < 5; c++) cyc(1, col(10 * c, 1), 5, 0, 0);
    idle(14);
    check("burst_done_pulses", W'(done_cnt), W'(1));
    check("burst_lanes_used", W'(ov_or), W'(10'h01F));
    start();
    for (int c = 0; c < 3; c++) cyc(1, col(10 * c, 1), 5, 0, 0);
    cyc(1, col(99, 1), 5, 1, 0);
    cyc(0, '0, 5, 1, 0);
    for (int c = 3; c < 5; c++) cyc(1, col(10 * c, 1), 5, 0, 0);
    idle(16);
    check("stall_done_pulses", W'(done_cnt), W'(1));
    for (int i = 0; i < 3; i++) begin
      start();
      cyc(1, col(127, 0), dys[i], 0, 0);
      idle(13);
      check("mask_valid", W'(ov_or), W'(ovx[i]));
    end
    start();
    for (int c = 0; c < 3; c++) cyc(1, col(c + 1, 3), 10, 0, 0);
    idle(1);
    cyc(0, '0, 10, 0, 1);
    check("clr_busy", W'(busy), W'(0));
    check("clr_vec", W'(vec_count), W'(0));
    idle(12);
    check("clr_no_done", W'(done_cnt), W'(0));
    start();
    for (int c = 0; c < 3; c++) cyc(1, col(5 * c, 2), 10, 0, 0);
    #2 rst_n = 0;
    #1;
    check("rst_out_data", out_data, '0);
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_vec", W'(vec_count), W'(0));
    sb.delete(); vec_exp = 0; done_exp = 0; done_next = 0;
    #1 rst_n = 1;
    start();
    cyc(1, col(1, 1), 10, 0, 0);
    idle(14);
    check("rst_s1_done_cycle", W'(done_at), W'(11));
    check("rst_s1_vec", W'(vec_count), W'(1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
